bullet_pool: RTL
================

BULLET_POOL -- requirements
Module: bullet_pool

Interface
REQ-001 Parameter N_BULLETS, default 8, number of bullet slots (2..64).
REQ-002 Parameter COORD_W, default 8, width of x, y, w and h.
REQ-003 Parameter STEP, default 5, pixels moved per tick.
REQ-004 Parameter LIMIT, default 200, upper coordinate bound.
REQ-005 Parameter WRAP_VAL, default 1, re-entry coordinate for wrap mode.
REQ-006 Parameter WRAP_MODE, default 1, 1 = wrap at bound, 0 = retire at bound.
REQ-007 Parameter IDX_W, default $clog2(N_BULLETS), slot index width (derived).
REQ-008 clk  in  1  single clock; all state updates on rising edge.
REQ-009 rst_n  in  1  reset, asynchronous, active-low.
REQ-010 tick  in  1  one-cycle strobe; advance all active bullets.
REQ-011 spawn_valid  in  1  request to create a bullet.
REQ-012 spawn_ready  out  1  a free slot exists.
REQ-013 spawn_x, spawn_y, spawn_w, spawn_h  in  COORD_W each  new bullet position and size.
REQ-014 spawn_color  in  2  00 white, 01 green, 10 blue, 11 reserved.
REQ-015 spawn_dir  in  2  00 +y, 01 -y, 10 +x, 11 -x.
REQ-016 rd1_idx, rd2_idx  in  IDX_W  read-port slot selects (port 1 VGA, port 2 collision/damage).
REQ-017 rdN_x, rdN_y, rdN_w, rdN_h  out  COORD_W  slot fields for port N, N = 1, 2.
REQ-018 rdN_color  out  2, rdN_active  out  1  slot color and render flag.
REQ-019 hit  in  1  collision on slot rd2_idx; clears that slot.
REQ-020 active_count  out  IDX_W+1  number of active slots.

Function
REQ-021 Read ports: combinational; every field of port N, including w and h, taken from slot rdN_idx; index >= N_BULLETS reads all zero.
REQ-022 spawn_ready: combinational, 1 iff any slot is inactive in the registered state.
REQ-023 Spawn: spawn_valid & spawn_ready -> the lowest-index inactive slot loads all spawn fields, active=1, on the same edge.
REQ-024 A newly spawned bullet is not moved by a tick in its spawn cycle.
REQ-025 Tick, +dir: sum formed in COORD_W+1 bits; if pos+STEP > LIMIT -> boundary event, else pos = pos+STEP.
REQ-026 Tick, -dir: if pos < STEP -> boundary event, else pos = pos-STEP.
REQ-027 Boundary event, WRAP_MODE=1: +dir sets pos=WRAP_VAL; -dir sets pos=LIMIT; slot stays active.
REQ-028 Boundary event, WRAP_MODE=0: active cleared, position held.
REQ-029 Inactive slots are never moved by tick.
REQ-030 hit clears active of slot rd2_idx on the next edge; other fields held; hit on an inactive slot has no effect.
REQ-031 Priority on the same slot and edge: hit over tick (slot cleared, not moved).
REQ-032 A slot freed by hit or retire becomes spawnable from the following cycle only (allocator uses registered state).
REQ-033 active_count: registered, equal to the popcount of active flags after each edge; 0..N_BULLETS, never wraps.
REQ-034 spawn_valid with spawn_ready=0: request dropped; no state change.

Reset
REQ-035 rst_n low asynchronously clears every slot: active=0; x, y, w, h, color, dir = 0; active_count=0; spawn_ready=1 after reset.
REQ-036 Reset asserted mid-tick or mid-spawn discards the operation; the first edge after release is a normal cycle.

Verification
REQ-037 Reset, then spawn (x=16,y=19,dir=+y) -> slot 0 active, rd1 (idx 0) shows y=19, active_count=1.
REQ-038 Slot y=195, dir +y, tick, WRAP_MODE=1 -> y=200; next tick -> y=1, still active.
REQ-039 WRAP_MODE=0, slot x=3, dir -x, tick -> active=0, x=3, active_count decrements.
REQ-040 Fill all 8 slots -> spawn_ready=0; further spawn ignored; hit on slot 5 -> next spawn lands in slot 5, one cycle later.
REQ-041 Same cycle: tick, hit on slot 2, spawn -> slot 2 cleared and unmoved; spawn takes lowest free slot other than 2; new bullet unmoved.
REQ-042 rd1_idx=1, rd2_idx=2 with different sizes -> each port shows its own slot's w and h; assert rst_n mid-stream -> all outputs zero immediately.

Source files
------------

// File: rtl/bullet_pool.sv
// Fixed-size pool of moving bullets: lowest-free-slot spawn, per-tick motion with
// wrap or retire at the coordinate bounds, two combinational read ports, hit clear.
module bullet_pool #(
  parameter int N_BULLETS = 8,
  parameter int COORD_W   = 8,
  parameter int STEP      = 5,
  parameter int LIMIT     = 200,
  parameter int WRAP_VAL  = 1,
  parameter int WRAP_MODE = 1,
  parameter int IDX_W     = $clog2(N_BULLETS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               spawn_valid,
  output logic               spawn_ready,
  input  logic [COORD_W-1:0] spawn_x,
  input  logic [COORD_W-1:0] spawn_y,
  input  logic [COORD_W-1:0] spawn_w,
  input  logic [COORD_W-1:0] spawn_h,
  input  logic [1:0]         spawn_color,
  input  logic [1:0]         spawn_dir,
  input  logic [IDX_W-1:0]   rd1_idx,
  input  logic [IDX_W-1:0]   rd2_idx,
  output logic [COORD_W-1:0] rd1_x,
  output logic [COORD_W-1:0] rd1_y,
  output logic [COORD_W-1:0] rd1_w,
  output logic [COORD_W-1:0] rd1_h,
  output logic [1:0]         rd1_color,
  output logic               rd1_active,
  output logic [COORD_W-1:0] rd2_x,
  output logic [COORD_W-1:0] rd2_y,
  output logic [COORD_W-1:0] rd2_w,
  output logic [COORD_W-1:0] rd2_h,
  output logic [1:0]         rd2_color,
  output logic               rd2_active,
  input  logic               hit,
  output logic [IDX_W:0]     active_count
);

  localparam logic [COORD_W:0]   STEP_E  = (COORD_W+1)'(STEP);
  localparam logic [COORD_W:0]   LIMIT_E = (COORD_W+1)'(LIMIT);
  localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] LIMIT_C = COORD_W'(LIMIT);
  localparam logic [COORD_W-1:0] WRAP_C  = COORD_W'(WRAP_VAL);

  logic [COORD_W-1:0] x_q [N_BULLETS];
  logic [COORD_W-1:0] x_d [N_BULLETS];
  logic [COORD_W-1:0] y_q [N_BULLETS];
  logic [COORD_W-1:0] y_d [N_BULLETS];
  logic [COORD_W-1:0] w_q [N_BULLETS];
  logic [COORD_W-1:0] w_d [N_BULLETS];
  logic [COORD_W-1:0] h_q [N_BULLETS];
  logic [COORD_W-1:0] h_d [N_BULLETS];
  logic [1:0]         color_q [N_BULLETS];
  logic [1:0]         color_d [N_BULLETS];
  logic [1:0]         dir_q [N_BULLETS];
  logic [1:0]         dir_d [N_BULLETS];
  logic [N_BULLETS-1:0] active_q, active_d;
  logic [IDX_W:0]     active_count_q, active_count_d;

  logic               free_found;
  logic [IDX_W-1:0]   spawn_idx;
  logic               spawn_fire;
  logic [COORD_W-1:0] pos, npos;
  logic [COORD_W:0]   sum;
  logic               bnd;

  // Allocation looks only at registered flags, so a slot freed this edge is reusable next cycle.
  always_comb begin
    free_found = 1'b0;
    spawn_idx  = '0;
    for (int unsigned i = 0; i < N_BULLETS; i++) begin
      if (!free_found && !active_q[i]) begin
        free_found = 1'b1;
        spawn_idx  = IDX_W'(i);
      end
    end
  end

  assign spawn_ready = free_found;
  assign spawn_fire  = spawn_valid & free_found;

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    w_d      = w_q;
    h_d      = h_q;
    color_d  = color_q;
    dir_d    = dir_q;
    active_d = active_q;
    pos      = '0;
    npos     = '0;
    sum      = '0;
    bnd      = 1'b0;
    for (int unsigned i = 0; i < N_BULLETS; i++) begin
      pos  = dir_q[i][1] ? x_q[i] : y_q[i];
      npos = pos;
      bnd  = 1'b0;
      sum  = {1'b0, pos} + STEP_E;
      if (!dir_q[i][0]) begin
        if (sum > LIMIT_E) bnd = 1'b1;
        else               npos = sum[COORD_W-1:0];
      end else begin
        if ({1'b0, pos} < STEP_E) bnd = 1'b1;
        else                      npos = pos - STEP_C;
      end
      if (bnd) npos = (WRAP_MODE != 0) ? (dir_q[i][0] ? LIMIT_C : WRAP_C) : pos;

      // Spawn targets only an inactive slot; hit outranks tick on an active one.
      if (spawn_fire && spawn_idx == IDX_W'(i)) begin
        x_d[i]      = spawn_x;
        y_d[i]      = spawn_y;
        w_d[i]      = spawn_w;
        h_d[i]      = spawn_h;
        color_d[i]  = spawn_color;
        dir_d[i]    = spawn_dir;
        active_d[i] = 1'b1;
      end else if (hit && rd2_idx == IDX_W'(i)) begin
        active_d[i] = 1'b0;
      end else if (tick && active_q[i]) begin
        if (bnd && WRAP_MODE == 0) active_d[i] = 1'b0;
        if (dir_q[i][1]) x_d[i] = npos;
        else             y_d[i] = npos;
      end
    end
  end

  always_comb begin
    active_count_d = '0;
    for (int unsigned i = 0; i < N_BULLETS; i++) begin
      active_count_d = active_count_d + (IDX_W+1)'(active_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q            <= '{default: '0};
      y_q            <= '{default: '0};
      w_q            <= '{default: '0};
      h_q            <= '{default: '0};
      color_q        <= '{default: '0};
      dir_q          <= '{default: '0};
      active_q       <= '0;
      active_count_q <= '0;
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      w_q            <= w_d;
      h_q            <= h_d;
      color_q        <= color_d;
      dir_q          <= dir_d;
      active_q       <= active_d;
      active_count_q <= active_count_d;
    end
  end

  assign active_count = active_count_q;

  always_comb begin
    rd1_x = '0; rd1_y = '0; rd1_w = '0; rd1_h = '0; rd1_color = '0; rd1_active = 1'b0;
    rd2_x = '0; rd2_y = '0; rd2_w = '0; rd2_h = '0; rd2_color = '0; rd2_active = 1'b0;
    if (int'(rd1_idx) < N_BULLETS) begin
      rd1_x      = x_q[rd1_idx];
      rd1_y      = y_q[rd1_idx];
      rd1_w      = w_q[rd1_idx];
      rd1_h      = h_q[rd1_idx];
      rd1_color  = color_q[rd1_idx];
      rd1_active = active_q[rd1_idx];
    end
    if (int'(rd2_idx) < N_BULLETS) begin
      rd2_x      = x_q[rd2_idx];
      rd2_y      = y_q[rd2_idx];
      rd2_w      = w_q[rd2_idx];
      rd2_h      = h_q[rd2_idx];
      rd2_color  = color_q[rd2_idx];
      rd2_active = active_q[rd2_idx];
    end
  end

endmodule
